// File: rtl/wb_queue_if.sv
// wb_queue_if: MEM-stage request, ID-stage hazard query and register-file write port of the writeback queue
interface wb_queue_if #(parameter int DEPTH = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_wb_en;
  logic                     in_mem_r_en;
  logic [3:0]               in_dest;
  logic [31:0]              in_alu_result;
  logic [31:0]              in_mem_data;
  logic [3:0]               src_1;
  logic [3:0]               src_2;
  logic                     hazard;
  logic [$clog2(DEPTH):0]   level;
  logic [3:0]               Dest_WB;
  logic [31:0]              Result_WB;
  logic                     writeBackEN;
  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, in_mem_data, src_1, src_2,
    input  in_ready, hazard, level, Dest_WB, Result_WB, writeBackEN
  );
  modport slave (
    input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, in_mem_data, src_1, src_2,
    output in_ready, hazard, level, Dest_WB, Result_WB, writeBackEN
  );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: FIFO of register writebacks retiring one write per cycle, with a source-register hazard query
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic   clk,
  input logic   rst,
  wb_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]       dest_m [DEPTH];
  logic [31:0]      data_m [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    head, tail;
  logic [AW:0]      cnt;
  logic [3:0]       dest_r;
  logic [31:0]      res_r;
  logic             en_r, push, pop, hz;
  assign q.in_ready    = cnt != (AW+1)'(DEPTH);
  assign q.level       = cnt;
  assign q.hazard      = hz;
  assign q.Dest_WB     = dest_r;
  assign q.Result_WB   = res_r;
  assign q.writeBackEN = en_r;
  assign push = q.in_valid && q.in_ready && q.in_wb_en;
  assign pop  = cnt != '0;
  // the popped entry is already invalid, so the one in the output registers never raises hazard
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hz = hz | (vld[i] && (dest_m[i] == q.src_1 || dest_m[i] == q.src_2));
  end
  always_ff @(posedge clk) begin
    if (push) begin
      dest_m[tail] <= q.in_dest;
      data_m[tail] <= q.in_mem_r_en ? q.in_mem_data : q.in_alu_result;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      dest_r <= '0;
      res_r  <= '0;
      en_r   <= 1'b0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + AW'(1);
        dest_r    <= dest_m[head];
        res_r     <= data_m[head];
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + AW'(1);
      end
      en_r <= pop;
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed checks of wb_queue against a queue-based reference model
module tb_wb_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wb_queue_if #(.DEPTH(DEPTH)) q();
  wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [35:0] mq [$];
  logic        exp_en = 1'b0;
  logic [3:0]  exp_dest = '0;
  logic [31:0] exp_res = '0;
  function automatic logic hz_model();
    foreach (mq[i]) if (mq[i][35:32] == q.src_1 || mq[i][35:32] == q.src_2) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drive(input logic v, w, m, input logic [3:0] d, input logic [31:0] a, md);
    q.in_valid = v; q.in_wb_en = w; q.in_mem_r_en = m;
    q.in_dest = d; q.in_alu_result = a; q.in_mem_data = md;
  endtask
  task automatic tick();
    int was;
    logic [35:0] e;
    was = mq.size();
    if (q.in_valid && was != DEPTH && q.in_wb_en)
      mq.push_back({q.in_dest, q.in_mem_r_en ? q.in_mem_data : q.in_alu_result});
    if (was > 0) begin
      e = mq.pop_front();
      exp_en = 1'b1; exp_dest = e[35:32]; exp_res = e[31:0];
    end else exp_en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    q.src_1 = 0; q.src_2 = 0;
    #1;
    total++; if ({q.writeBackEN, q.Dest_WB, q.Result_WB} !== 37'd0) begin bad++; $display("FAIL reset_out got %b/%h/%h exp 0", q.writeBackEN, q.Dest_WB, q.Result_WB); end
    total++; if ({q.level, q.in_ready, q.hazard} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL reset_state got level=%0d ready=%b hz=%b", q.level, q.in_ready, q.hazard); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    drive(1, 1, 0, 4'd5, 32'hAA, 32'h0);
    tick();
    total++; if (q.writeBackEN !== 1'b0 || q.level !== 3'd1) begin bad++; $display("FAIL single_k got en=%b level=%0d exp en=0 level=1", q.writeBackEN, q.level); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if ({q.writeBackEN, q.Dest_WB, q.Result_WB} !== {1'b1, 4'd5, 32'hAA}) begin bad++; $display("FAIL single_k1 got %b/%h/%h exp 1/5/aa", q.writeBackEN, q.Dest_WB, q.Result_WB); end
    tick();
    total++; if (q.writeBackEN !== 1'b0 || q.Result_WB !== 32'hAA) begin bad++; $display("FAIL single_k2 got en=%b res=%h exp en=0 res=aa", q.writeBackEN, q.Result_WB); end
  endtask
  task automatic test_load_bubble();
    drive(1, 1, 1, 4'd3, 32'h1, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if ({q.writeBackEN, q.Dest_WB, q.Result_WB} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin bad++; $display("FAIL load_sel got %b/%h/%h exp 1/3/deadbeef", q.writeBackEN, q.Dest_WB, q.Result_WB); end
    drive(1, 0, 0, 4'd12, 32'h77, 32'h88);
    #1;
    total++; if (q.in_ready !== 1'b1) begin bad++; $display("FAIL bubble_ready got %b exp 1", q.in_ready); end
    tick();
    total++; if (q.level !== 3'd0 || q.writeBackEN !== 1'b0) begin bad++; $display("FAIL bubble_level got level=%0d en=%b exp 0/0", q.level, q.writeBackEN); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (q.writeBackEN !== 1'b0 || q.Result_WB !== 32'hDEADBEEF) begin bad++; $display("FAIL bubble_nowrite got en=%b res=%h exp 0/deadbeef", q.writeBackEN, q.Result_WB); end
  endtask
  task automatic test_hazard();
    q.src_1 = 4'd7; q.src_2 = 4'd0;
    drive(1, 1, 0, 4'd7, 32'h70, 0);
    #1;
    total++; if (q.hazard !== 1'b0) begin bad++; $display("FAIL hz_empty got %b exp 0", q.hazard); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (q.hazard !== 1'b1) begin bad++; $display("FAIL hz_queued7 got %b exp 1", q.hazard); end
    tick();
    total++; if (q.writeBackEN !== 1'b1 || q.hazard !== 1'b0) begin bad++; $display("FAIL hz_retired got en=%b hz=%b exp 1/0", q.writeBackEN, q.hazard); end
    q.src_1 = 4'd2; q.src_2 = 4'd9;
    drive(1, 1, 0, 4'd9, 32'h90, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (q.hazard !== 1'b1) begin bad++; $display("FAIL hz_src2 got %b exp 1", q.hazard); end
    tick();
    q.src_1 = 4'd0; q.src_2 = 4'd15;
    drive(1, 1, 0, 4'd15, 32'hF0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (q.hazard !== 1'b1) begin bad++; $display("FAIL hz_r15 got %b exp 1", q.hazard); end
    tick();
    total++; if (q.hazard !== 1'b0 || q.Dest_WB !== 4'd15) begin bad++; $display("FAIL hz_r15_ret got hz=%b dest=%0d exp 0/15", q.hazard, q.Dest_WB); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] got [$];
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, 4'(i), 32'(i), 0);
      #1;
      total++; if (q.in_ready !== (mq.size() != DEPTH) || q.level !== 3'(mq.size())) begin bad++; $display("FAIL b2b_flow[%0d] got ready=%b level=%0d exp level=%0d", i, q.in_ready, q.level, mq.size()); end
      tick();
      if (q.writeBackEN) got.push_back(q.Result_WB);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin tick(); if (q.writeBackEN) got.push_back(q.Result_WB); end
    total++; if (got.size() != 5) begin bad++; $display("FAIL b2b_count got %0d exp 5", got.size()); end
    foreach (got[i]) begin
      total++; if (got[i] !== 32'(i + 1)) begin bad++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, got[i], i + 1); end
    end
  endtask
  task automatic test_wrap();
    logic [31:0] got [$];
    for (int i = 1; i <= 10; i++) begin
      drive(1, 1, i % 2 == 0, 4'd4, 32'(i), 32'(i));
      tick();
      if (q.writeBackEN) begin
        got.push_back(q.Result_WB);
        total++; if (q.Dest_WB !== 4'd4) begin bad++; $display("FAIL wrap_dest got %0d exp 4", q.Dest_WB); end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) begin tick(); if (q.writeBackEN) got.push_back(q.Result_WB); end
    foreach (got[i]) begin
      total++; if (got[i] !== 32'(i + 1)) begin bad++; $display("FAIL wrap_order[%0d] got %0d exp %0d", i, got[i], i + 1); end
    end
    total++; if (got.size() != 10 || q.Result_WB !== 32'd10) begin bad++; $display("FAIL wrap_final got n=%0d res=%0d exp 10/10", got.size(), q.Result_WB); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom), $urandom, $urandom);
      q.src_1 = 4'($urandom); q.src_2 = 4'($urandom);
      #1;
      total++; if (q.level !== 3'(mq.size()) || q.in_ready !== (mq.size() != DEPTH) || q.hazard !== hz_model()) begin bad++; $display("FAIL rnd_comb[%0d] got level=%0d ready=%b hz=%b exp level=%0d hz=%b", n, q.level, q.in_ready, q.hazard, mq.size(), hz_model()); end
      tick();
      total++; if ({q.writeBackEN, q.Dest_WB, q.Result_WB} !== {exp_en, exp_dest, exp_res}) begin bad++; $display("FAIL rnd_out[%0d] got %b/%h/%h exp %b/%h/%h", n, q.writeBackEN, q.Dest_WB, q.Result_WB, exp_en, exp_dest, exp_res); end
    end
  endtask
  task automatic test_reset_mid();
    drive(1, 1, 0, 4'd6, 32'h11, 0);
    tick();
    q.src_1 = 4'd8; q.src_2 = 4'd6;
    drive(1, 1, 0, 4'd8, 32'h22, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (q.hazard !== 1'b1 || q.writeBackEN !== 1'b1) begin bad++; $display("FAIL rstmid_pre got hz=%b en=%b exp 1/1", q.hazard, q.writeBackEN); end
    #1 rst = 1'b1;
    #1;
    total++; if ({q.writeBackEN, q.Dest_WB, q.Result_WB} !== 37'd0) begin bad++; $display("FAIL rstmid_out got %b/%h/%h exp 0", q.writeBackEN, q.Dest_WB, q.Result_WB); end
    total++; if ({q.level, q.in_ready, q.hazard} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL rstmid_state got level=%0d ready=%b hz=%b", q.level, q.in_ready, q.hazard); end
    mq.delete(); exp_en = 1'b0; exp_dest = '0; exp_res = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    repeat (2) begin
      tick();
      total++; if (q.writeBackEN !== 1'b0 || q.Result_WB !== 32'd0) begin bad++; $display("FAIL rstmid_stale got en=%b res=%h exp 0/0", q.writeBackEN, q.Result_WB); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_load_bubble();
    test_hazard();
    test_back_to_back();
    test_wrap();
    mq.delete();
    exp_dest = q.Dest_WB; exp_res = q.Result_WB;
    test_random();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
